// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one combinational IEEE-754 single adder among NREQ requesters, with a valid/ready tagged response.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_sub per requester (operands packed 32 bits each);
// rsp_valid/rsp_ready/rsp_sum/rsp_id response handshake; busy is high outside IDLE.
// Optional feature: define FP_ARB_SUB_EN to let req_sub turn a request into a-b.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] x_l, x_s;
  logic [7:0]  e_l, e_s, d;
  logic [23:0] m_l, m_s;
  logic [26:0] al_s, n;
  logic [27:0] sum;
  logic [8:0]  lz, sh, e_n, e_r;
  logic [24:0] m_r;
  logic        sub, up;
  always_comb begin
    x_l  = (a[30:0] >= b[30:0]) ? a : b;
    x_s  = (a[30:0] >= b[30:0]) ? b : a;
    e_l  = (x_l[30:23] == 8'd0) ? 8'd1 : x_l[30:23];
    e_s  = (x_s[30:23] == 8'd0) ? 8'd1 : x_s[30:23];
    m_l  = {x_l[30:23] != 8'd0, x_l[22:0]};
    m_s  = {x_s[30:23] != 8'd0, x_s[22:0]};
    d    = e_l - e_s;
    // smaller operand aligned with guard/round bits; everything shifted out folds into the sticky lsb
    al_s = (d > 8'd26) ? {26'b0, |m_s}
         : (({m_s, 3'b0} >> d) | {26'b0, |({m_s, 3'b0} & ((27'd1 << d) - 27'd1))});
    sub  = x_l[31] ^ x_s[31];
    sum  = sub ? {1'b0, m_l, 3'b0} - {1'b0, al_s} : {1'b0, m_l, 3'b0} + {1'b0, al_s};
    lz   = 9'd27;
    for (int i = 0; i < 27; i++)
      if (sum[i]) lz = 9'(26 - i);
    // left shift is capped so the exponent never drops below the denormal level
    sh   = (lz < {1'b0, e_l} - 9'd1) ? lz : {1'b0, e_l} - 9'd1;
    n    = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
    e_n  = sum[27] ? {1'b0, e_l} + 9'd1 : (n[26] ? {1'b0, e_l} - sh : 9'd0);
    up   = n[2] & (n[1] | n[0] | n[3]);
    m_r  = {1'b0, n[26:3]} + {24'b0, up};
    e_r  = m_r[24] ? e_n + 9'd1 : ((e_n == 9'd0 && m_r[23]) ? 9'd1 : e_n);
    y    = {x_l[31], e_r[7:0], m_r[24] ? 23'b0 : m_r[22:0]};
    if (e_r >= 9'd255) y = {x_l[31], 8'hFF, 23'b0};
    if (sum == 28'd0) y = 32'h0;
    if (x_s[30:0] == 31'd0) y = (x_l[30:0] == 31'd0) ? {a[31] & b[31], 31'b0} : x_l;
    if (x_l[30:23] == 8'hFF)
      y = (x_l[22:0] != 23'd0 || (sub && x_s[30:0] == x_l[30:0])) ? 32'h7FC00000 : x_l;
  end
endmodule

module fp_add_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_sum,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, g;
  logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d, rsp_sum_q, rsp_sum_d, sum, b_g;
  logic            rsp_valid_q, rsp_valid_d, hit, acc;
`ifndef FP_ARB_SUB_EN
  logic            unused_sub;
  assign unused_sub = ^req_sub;
`endif
  fp_adder u_add (.a(op_a_q), .b(op_b_q), .y(sum));
  always_comb begin
    g   = '0;
    hit = 1'b0;
    // descending scan so the lowest offset from rr_ptr wins
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        g   = ID_W'((int'(rr_ptr_q) + k) % NREQ);
        hit = 1'b1;
      end
    b_g = req_b[32*g +: 32];
`ifdef FP_ARB_SUB_EN
    b_g[31] = b_g[31] ^ req_sub[g];
`endif
    req_ready   = (state_q == IDLE && hit) ? NREQ'(1) << g : '0;
    acc         = |(req_valid & req_ready);
    state_d     = (state_q == IDLE) ? (acc ? CALC : IDLE)
                : (state_q == CALC) ? RESP : (rsp_ready ? IDLE : RESP);
    op_a_d      = acc ? req_a[32*g +: 32] : op_a_q;
    op_b_d      = acc ? b_g : op_b_q;
    id_d        = acc ? g : id_q;
    rr_ptr_d    = acc ? ((g == ID_W'(NREQ - 1)) ? '0 : g + 1'b1) : rr_ptr_q;
    rsp_valid_d = (state_q == CALC) ? 1'b1 : ((state_q == RESP && rsp_ready) ? 1'b0 : rsp_valid_q);
    rsp_sum_d   = (state_q == CALC) ? sum : rsp_sum_q;
    rsp_id_d    = (state_q == CALC) ? id_q : rsp_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: directed vectors with hand-computed sums, grants and ids for fp_add_arbiter.
module tb_fp_add_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   req_sub = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;
  logic         busy;
  int           n_vec = 0;
  int           n_err = 0;
`ifdef FP_ARB_SUB_EN
  localparam logic [31:0] SUB_EXP = 32'h40000000;
`else
  localparam logic [31:0] SUB_EXP = 32'h40800000;
`endif
  localparam logic [31:0] A_TAB [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  fp_add_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [31:0] exp_sum, input string tag);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_sub[idx] = s;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(req_ready), 32'(4'b1 << idx));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick;
    req_valid = '0;
    check({tag, "_calc_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_calc_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_calc_busy"}, 32'(busy), 32'd1);
    tick;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_sum"}, rsp_sum, exp_sum);
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    tick;
    check({tag, "_retire"}, 32'(rsp_valid), 32'd0);
    check({tag, "_retire_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_sum", rsp_sum, 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "add_1_2");
    op(2, 32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, "cancel");
    op(1, 32'h40400000, 32'h3F800000, 1'b1, SUB_EXP, "sub_opt");
    // rsp_ready held low for several cycles while the response is pending
    req_valid = 4'b1000;
    req_a[96 +: 32] = 32'h3F800000;
    req_b[96 +: 32] = 32'h3F800000;
    req_sub = '0;
    rsp_ready = 1'b0;
    #1;
    check("hold_grant", 32'(req_ready), 32'h8);
    tick;
    req_valid = 4'b1111;
    tick;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_sum", rsp_sum, 32'h40000000);
      check("hold_id", 32'(rsp_id), 32'd3);
      check("hold_ready", 32'(req_ready), 32'd0);
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    check("hold_retire", 32'(rsp_valid), 32'd0);
    check("hold_wrap_grant", 32'(req_ready), 32'h1);
    // reset while an operation sits in CALC
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'h3F800000;
    req_b[64 +: 32] = 32'h3F800000;
    #1;
    check("abort_grant", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    check("abort_busy_calc", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      tick;
    end
    check("abort_sum", rsp_sum, 32'd0);
    // continuous requests from everyone: rotation 0,1,2,3,0 with zero b returning a unchanged
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = A_TAB[i];
      req_b[32*i +: 32] = 32'h0;
    end
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(req_ready), 32'(4'b1 << (k % 4)));
      tick;
      tick;
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_sum", rsp_sum, A_TAB[k % 4]);
      tick;
    end
    req_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
